// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with show-ahead receive FIFO and sticky overrun flag
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    // Sample point half a bit into the start bit, then one full bit per sample.
    localparam logic [15:0]   HALF_M1   = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [15:0]   FULL_M1   = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                 rxd_meta;
    logic                 rxd_sync;
    state_t               state;
    logic [15:0]          baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_err_r;
    logic                 stop_err;

    logic                 start_tick;
    logic                 bit_tick;
    logic                 push;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic [EW-1:0]        head;

    // Two-flop synchronizer; idle-high reset value keeps the line from looking like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    assign start_tick = (baud_cnt == HALF_M1);
    assign bit_tick   = (baud_cnt == FULL_M1);

    // The final stop sample pushes the completed frame in the same cycle it is taken.
    assign push       = (state == S_STOP) && bit_tick && (bit_cnt == LAST_STOP);
    assign push_entry = {shift, stop_err | ~rxd_sync, parity_err_r};

    // Receive FSM; counters reload on every state entry so timing never accumulates error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            parity_err_r <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxd_sync) begin
                        state        <= S_START;
                        baud_cnt     <= '0;
                        bit_cnt      <= '0;
                        parity_err_r <= 1'b0;
                        stop_err     <= 1'b0;
                    end
                end
                S_START: begin
                    if (start_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rxd_sync ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        shift    <= {rxd_sync, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        baud_cnt     <= '0;
                        bit_cnt      <= '0;
                        parity_err_r <= ((^shift) ^ rxd_sync) != ODD_PAR;
                        state        <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        if (!rxd_sync) begin
                            stop_err <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            state   <= rxd_sync ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd_sync) begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    assign full   = (count == DEPTH_C);
    assign pop    = rx_valid && rx_ready;
    assign accept = push && (!full || pop);

    // FIFO storage; contents need no reset because outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun: a dropped frame wins over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

    assign head          = mem[rd_ptr];
    assign rx_valid      = (count != '0);
    assign fifo_count    = count;
    assign rx_data       = rx_valid ? head[EW-1:2] : '0;
    assign rx_frame_err  = rx_valid ? head[1] : 1'b0;
    assign rx_parity_err = rx_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 8E1 instances)
module tb_uart_rx_fifo;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd0, rxd2;
    logic       ready0, ready2;
    logic       clr0, clr2;
    logic [7:0] data0, data2;
    logic       fe0, fe2, pe0, pe2, valid0, valid2, ovr0, ovr2;
    logic [2:0] cnt0, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] pop_log0[$];
    logic [9:0] model_q[$];
    logic       exp_ovr;

    always #20 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .resetn(resetn), .rxd(rxd0), .rx_data(data0), .rx_frame_err(fe0),
        .rx_parity_err(pe0), .rx_valid(valid0), .rx_ready(ready0), .overrun(ovr0),
        .err_clr(clr0), .fifo_count(cnt0)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .resetn(resetn), .rxd(rxd2), .rx_data(data2), .rx_frame_err(fe2),
        .rx_parity_err(pe2), .rx_valid(valid2), .rx_ready(ready2), .overrun(ovr2),
        .err_clr(clr2), .fifo_count(cnt2)
    );

    always @(posedge clk) begin
        if (valid0 && ready0) pop_log0.push_back({fe0, pe0, data0});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rxd0 = b;
        else          rxd2 = b;
    endtask

    task automatic idle(input int sel, input int bits);
        set_line(sel, 1'b1);
        wait_clk(bits * CPB);
    endtask

    // Line ends the task at the stop-bit level so callers can model a break.
    task automatic send(input int sel, input logic [7:0] d, input logic use_par,
                        input logic pbit, input logic stopb);
        set_line(sel, 1'b0);
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            wait_clk(CPB);
        end
        if (use_par) begin
            set_line(sel, pbit);
            wait_clk(CPB);
        end
        set_line(sel, stopb);
        wait_clk(CPB);
    endtask

    task automatic pop_chk(input int sel, input string tag, input logic [7:0] d,
                           input logic fe, input logic pe);
        if (sel == 0) begin
            chk({tag, "_valid"}, valid0, 1'b1);
            chk({tag, "_entry"}, {fe0, pe0, data0}, {fe, pe, d});
            ready0 = 1'b1;
            wait_clk(1);
            ready0 = 1'b0;
        end else begin
            chk({tag, "_valid"}, valid2, 1'b1);
            chk({tag, "_entry"}, {fe2, pe2, data2}, {fe, pe, d});
            ready2 = 1'b1;
            wait_clk(1);
            ready2 = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       pbit, stopb, good;
        int         n;

        resetn = 1'b0;
        rxd0 = 1'b1; rxd2 = 1'b1;
        ready0 = 1'b0; ready2 = 1'b0;
        clr0 = 1'b0; clr2 = 1'b0;
        exp_ovr = 1'b0;
        wait_clk(3);
        chk("rst_outputs0", {data0, fe0, pe0, valid0, ovr0, cnt0}, 16'h0);
        chk("rst_outputs2", {data2, fe2, pe2, valid2, ovr2, cnt2}, 16'h0);
        resetn = 1'b1;
        wait_clk(5);

        // 8N1 single frame with consumer always ready
        ready0 = 1'b1;
        send(0, 8'h34, 1'b0, 1'b0, 1'b1);
        idle(0, 2);
        ready0 = 1'b0;
        chk("8n1_pops", pop_log0.size(), 1);
        if (pop_log0.size() > 0) chk("8n1_data", pop_log0[0], 10'h034);
        chk("8n1_count", cnt0, 0);

        // Start-bit glitch is rejected
        set_line(0, 1'b0);
        wait_clk(50);
        set_line(0, 1'b1);
        wait_clk(2 * CPB);
        chk("glitch_count", cnt0, 0);
        chk("glitch_valid", valid0, 1'b0);

        // Framing error followed by a held-low line yields a single entry
        send(0, 8'h2A, 1'b0, 1'b0, 1'b0);
        wait_clk(3 * CPB);
        chk("break_count", cnt0, 1);
        chk("break_entry", {fe0, pe0, data0}, 10'h22A);
        idle(0, 2);
        chk("break_release_count", cnt0, 1);
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        chk("after_break_count", cnt0, 2);
        pop_chk(0, "break_pop0", 8'h2A, 1'b1, 1'b0);
        pop_chk(0, "break_pop1", 8'h11, 1'b0, 1'b0);
        chk("break_drained", cnt0, 0);

        // Overrun: five frames into a four-entry FIFO
        for (int v = 8'h30; v <= 8'h34; v++) begin
            send(0, 8'(v), 1'b0, 1'b0, 1'b1);
            idle(0, 1);
        end
        chk("ovr_count", cnt0, 4);
        chk("ovr_flag", ovr0, 1'b1);
        for (int v = 8'h30; v <= 8'h33; v++) pop_chk(0, "ovr_pop", 8'(v), 1'b0, 1'b0);
        chk("ovr_drained", cnt0, 0);
        chk("ovr_sticky", ovr0, 1'b1);
        clr0 = 1'b1;
        wait_clk(1);
        clr0 = 1'b0;
        chk("ovr_clear", ovr0, 1'b0);

        // Reset mid-frame discards the partial frame and the FIFO contents
        send(0, 8'h55, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        chk("pre_reset_count", cnt0, 1);
        d = 8'h39;
        set_line(0, 1'b0);
        wait_clk(CPB);
        for (int i = 0; i < 3; i++) begin
            set_line(0, d[i]);
            wait_clk(CPB);
        end
        set_line(0, d[3]);
        wait_clk(CPB / 2);
        resetn = 1'b0;
        wait_clk(2);
        chk("midreset_outputs", {data0, fe0, pe0, valid0, ovr0, cnt0}, 16'h0);
        set_line(0, 1'b1);
        wait_clk(2);
        resetn = 1'b1;
        wait_clk(2 * CPB);
        chk("post_reset_count", cnt0, 0);
        send(0, 8'h2F, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        chk("post_reset_frame_count", cnt0, 1);
        pop_chk(0, "post_reset_pop", 8'h2F, 1'b0, 1'b0);

        // Even parity: 0x35 has four ones, so parity bit 0 is correct
        send(2, 8'h35, 1'b1, 1'b0, 1'b1);
        idle(2, 1);
        pop_chk(2, "par_good", 8'h35, 1'b0, 1'b0);
        send(2, 8'h35, 1'b1, 1'b1, 1'b1);
        idle(2, 1);
        pop_chk(2, "par_bad", 8'h35, 1'b0, 1'b1);

        // Randomized bursts against a queue model of the FIFO
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 5);
            for (int f = 0; f < n; f++) begin
                d     = 8'($urandom);
                good  = ($urandom_range(0, 3) != 0);
                pbit  = ($countones(d) % 2 == 1) ? good : !good;
                stopb = ($urandom_range(0, 4) != 0);
                send(2, d, 1'b1, pbit, stopb);
                idle(2, 1);
                if (model_q.size() < 4)
                    model_q.push_back({!stopb, (($countones(d) + int'(pbit)) % 2) != 0, d});
                else
                    exp_ovr = 1'b1;
            end
            chk("rnd_count", cnt2, model_q.size());
            chk("rnd_ovr", ovr2, exp_ovr);
            while (model_q.size() > 0) begin
                pop_chk(2, "rnd_pop", model_q[0][7:0], model_q[0][9], model_q[0][8]);
                void'(model_q.pop_front());
            end
            clr2 = 1'b1;
            wait_clk(1);
            clr2 = 1'b0;
            exp_ovr = 1'b0;
            chk("rnd_ovr_clear", ovr2, 1'b0);
            chk("rnd_empty", valid2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clk cycles per UART bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1, 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS, FIFO head data.
REQ-010 SHALL have port rx_frame_err, output, 1, framing-error flag of the FIFO head entry.
REQ-011 SHALL have port rx_parity_err, output, 1, parity-error flag of the FIFO head entry (always 0 when PARITY=0).
REQ-012 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-013 SHALL have port rx_ready, input, 1, consumer accepts the head entry.
REQ-014 SHALL have port overrun, output, 1, sticky flag: a frame was dropped because the FIFO was full.
REQ-015 SHALL have port err_clr, input, 1, synchronous clear of overrun.
REQ-016 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, number of entries held.

Function
REQ-017 SHALL pass rxd through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE -> START SHALL occur when the synchronized rxd is 0.
REQ-020 START SHALL wait floor(CLKS_PER_BIT/2) cycles, then resample: 0 -> DATA; 1 -> IDLE, treated as a glitch, with no push.
REQ-021 DATA SHALL sample one bit every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples; the next state is PARITY if PARITY!=0, otherwise STOP.
REQ-022 PARITY SHALL sample one bit after CLKS_PER_BIT cycles; parity_err = (XOR of data bits XOR parity bit) != (PARITY==1 ? 1 : 0).
REQ-023 STOP SHALL sample STOP_BITS stop bits at CLKS_PER_BIT spacing; frame_err = 1 if any stop sample is 0.
REQ-024 The cycle of the final stop sample SHALL push {data, frame_err, parity_err} into the FIFO; the next state is IDLE if that sample is 1, otherwise WAIT_HIGH.
REQ-025 WAIT_HIGH SHALL return to IDLE when the synchronized rxd is 1, so a held-low line (break) yields exactly one entry.
REQ-026 The FIFO SHALL be show-ahead: rx_valid = (fifo_count != 0), with rx_data and both error outputs showing the head entry.
REQ-027 A pop SHALL occur when rx_valid && rx_ready; rx_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-028 A push SHALL be accepted when not full, or when full with a pop in the same cycle.
REQ-029 Otherwise a push while full SHALL drop the frame, set overrun, and leave FIFO contents unchanged.
REQ-030 overrun SHALL clear on err_clr; if err_clr and a new overrun coincide, overrun SHALL remain 1.
REQ-031 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Bit counter and baud counter SHALL reload on every state entry; no fractional-bit accumulation.

Reset
REQ-033 While resetn=0: state IDLE, counters 0, FIFO empty, fifo_count=0, rx_valid=0, overrun=0, rx_data=0, both error outputs 0, synchronizer flops at 1.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver SHALL wait in IDLE for a new falling edge.

Verification (CLKS_PER_BIT=217, clk period 40 ns, bit 8680 ns)
REQ-035 Scenario 8N1, send 0x34 with rx_ready=1 -> exactly one pop with rx_data=0x34, rx_frame_err=0, rx_parity_err=0.
REQ-036 Scenario glitch: rxd low for 50 cycles, then high -> no push, fifo_count=0, state returns to IDLE.
REQ-037 Scenario PARITY=2: send 0x35 with correct parity bit 0 -> parity_err=0; resend with bit 1 -> rx_data=0x35, rx_parity_err=1.
REQ-038 Scenario framing: send 0x2A with stop bit 0, then hold rxd low for 3 bit times -> one entry with rx_frame_err=1; a second entry only after rxd returns high and a new frame is sent.
REQ-039 Scenario overrun: FIFO_DEPTH=4, rx_ready=0, send 0x30..0x34 -> fifo_count=4, overrun=1; pops return 0x30, 0x31, 0x32, 0x33 in order; err_clr -> overrun=0.
REQ-040 Scenario reset: pulse resetn low during data bit 3 of 0x39 -> all outputs at reset values; a subsequent 0x2F frame is received intact.
